// File: rtl/tile_deck_shuffler_if.sv
// Tile write channel between the deck shuffler and the in-game tile store.
//   wr_valid  master->slave  tile write offered
//   wr_ready  slave->master  consumer accepts when wr_valid && wr_ready
//   wr_addr   master->slave  slot index
//   wr_data   master->slave  tile code {row[1:0], col[1:0], colour[5:0], flipped}
interface tile_deck_shuffler_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [10:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/tile_deck_shuffler.sv
// Builds a shuffled memory-game deck of NUM_TILES/2 colour pairs, shuffles the slots with an
// LFSR-driven Fisher-Yates pass, then streams every tile code over the write channel.
//   CLOCK_50  system clock (posedge)
//   reset     synchronous, active-high; aborts any deck in progress
//   start     request a new deck (honoured only when idle); seed captured with it
//   busy      high from the cycle after start until the done cycle
//   done      one-cycle pulse after the last tile write is accepted
//   wr        tile write channel (master side)
//   rd_addr   read address into the deck table
//   rd_data   registered tile code of deck[rd_addr]; 0 for addresses beyond the deck
module tile_deck_shuffler #(
    parameter int unsigned NUM_TILES = 10,
    parameter int unsigned NUM_COLS  = 4,
    parameter logic [15:0] LFSR_TAP  = 16'hB400,
    parameter logic [15:0] SEED_DFLT = 16'hACE1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          seed,
    output logic                 busy,
    output logic                 done,
    tile_deck_shuffler_if.master wr,
    input  logic [3:0]           rd_addr,
    output logic [10:0]          rd_data
);

    typedef enum logic [2:0] {
        StIdle, StFill, StPick, StSwapA, StSwapB, StEmit, StDone
    } state_e;

    localparam logic [3:0] LastSlot = 4'(NUM_TILES - 1);
    localparam logic [4:0] NumSlots = 5'(NUM_TILES);
    localparam logic [3:0] NumColsW = 4'(NUM_COLS);

    // The table holds colours only; row/col are a pure function of the slot index.
    function automatic logic [10:0] tile_code(input logic [3:0] slot, input logic [5:0] colour);
        return {2'(slot / NumColsW), 2'(slot % NumColsW), colour, 1'b0};
    endfunction

    state_e      state_q;
    logic        busy_q, done_q, wr_valid_q;
    logic [3:0]  wr_addr_q;
    logic [10:0] wr_data_q, rd_data_q;
    logic [15:0] lfsr_q;
    logic [3:0]  i_q, j_q, k_q;
    logic [5:0]  tmp_i_q, tmp_j_q;
    logic [5:0]  deck_q [NUM_TILES];

    logic [15:0] lfsr_next;
    logic [3:0]  cand;
    logic [3:0]  k_inc;
    logic        rd_hit;

    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAP) : (lfsr_q >> 1);
    assign cand      = lfsr_q[3:0];
    assign k_inc     = k_q + 4'd1;
    assign rd_hit    = {1'b0, rd_addr} < NumSlots;

    assign busy        = busy_q;
    assign done        = done_q;
    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign rd_data     = rd_data_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            lfsr_q     <= SEED_DFLT;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            tmp_i_q    <= '0;
            tmp_j_q    <= '0;
        end else begin
            rd_data_q <= rd_hit ? tile_code(rd_addr, deck_q[rd_addr]) : '0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        lfsr_q  <= (seed == '0) ? SEED_DFLT : seed;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    deck_q[k_q] <= 6'(k_q >> 1) + 6'd1;
                    if (k_q == LastSlot) begin
                        i_q     <= LastSlot;
                        state_q <= StPick;
                    end else begin
                        k_q <= k_inc;
                    end
                end
                StPick: begin
                    lfsr_q <= lfsr_next;
                    // Rejection sampling keeps the pick uniform over 0..i.
                    if (cand <= i_q) begin
                        j_q     <= cand;
                        state_q <= StSwapA;
                    end
                end
                StSwapA: begin
                    tmp_i_q <= deck_q[i_q];
                    tmp_j_q <= deck_q[j_q];
                    state_q <= StSwapB;
                end
                StSwapB: begin
                    deck_q[i_q] <= tmp_j_q;
                    deck_q[j_q] <= tmp_i_q;
                    if (i_q == 4'd1) begin
                        k_q        <= '0;
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= '0;
                        // Slot 0 is only touched by this final swap when j==0.
                        wr_data_q  <= tile_code(4'd0, (j_q == 4'd0) ? tmp_i_q : deck_q[0]);
                        state_q    <= StEmit;
                    end else begin
                        i_q     <= i_q - 4'd1;
                        state_q <= StPick;
                    end
                end
                StEmit: begin
                    if (wr.wr_ready) begin
                        if (k_q == LastSlot) begin
                            wr_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            k_q       <= k_inc;
                            wr_addr_q <= k_inc;
                            wr_data_q <= tile_code(k_inc, deck_q[k_inc]);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
